// File: rtl/ad7606_sample_scheduler.sv
// AD7606 conversion scheduler: periodic CONVST, BUSY handshake tracking and read-engine hand-off.
// Optional skipped-tick counter port overrun_cnt is enabled by defining AD7606_SCHED_OVERRUN_CNT_EN.
module ad7606_sample_scheduler #(
  parameter int unsigned CLK_FREQUENCY      = 30_000_000,
  parameter int unsigned SAMPLE_RATE_HZ     = 10_000,
  parameter int unsigned CONV_PULSE_TICKS   = 2,
  parameter int unsigned BUSY_TIMEOUT_TICKS = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        busy,
  input  logic        err_clr,
  input  logic        rd_done,
  output logic        conv,
  output logic        rd_start,
  output logic        sample_valid,
  output logic [15:0] seq,
  output logic        overrun,
  output logic        timeout,
  output logic        active
`ifdef AD7606_SCHED_OVERRUN_CNT_EN
  ,
  output logic [15:0] overrun_cnt
`endif
);

  localparam int unsigned PERIOD = CLK_FREQUENCY / SAMPLE_RATE_HZ;
  localparam int unsigned CW     = $clog2(PERIOD);
  localparam int unsigned PW     = (CONV_PULSE_TICKS > 1) ? $clog2(CONV_PULSE_TICKS) : 1;
  localparam int unsigned TW     = $clog2(BUSY_TIMEOUT_TICKS + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(CONV_PULSE_TICKS - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_READ
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic            busy_s1;
  logic            busy_s2;
  logic            busy_d;
  logic            busy_rise;
  logic            busy_fall;
  logic [PW-1:0]   pulse_cnt;
  logic [PW-1:0]   pulse_n;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_n;
  logic            rd_start_n;
  logic            valid_n;
  logic [15:0]     seq_n;
  logic            tmo_set;
  logic            ovr_set;

  assign tick      = enable && (cnt == CNT_LAST);
  assign busy_rise = busy_s2 && !busy_d;
  assign busy_fall = !busy_s2 && busy_d;
  assign ovr_set   = tick && (state != S_IDLE);

  // Held at the wrap value while disabled so enabling fires a tick at once.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt <= CNT_LAST;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
      busy_d  <= 1'b0;
    end else begin
      busy_s1 <= busy;
      busy_s2 <= busy_s1;
      busy_d  <= busy_s2;
    end
  end

  always_comb begin
    state_n    = state;
    pulse_n    = pulse_cnt;
    timer_n    = (timer >= TIMER_LAST) ? timer : timer + 1'b1;
    rd_start_n = 1'b0;
    valid_n    = 1'b0;
    seq_n      = seq;
    tmo_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) begin
          state_n = S_CONV;
          pulse_n = '0;
          timer_n = '0;
        end
      end
      S_CONV: begin
        if (pulse_cnt >= PULSE_LAST) begin
          state_n = S_WAIT_RISE;
        end else begin
          pulse_n = pulse_cnt + 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (busy_rise) begin
          state_n = S_WAIT_FALL;
          timer_n = '0;
        end else if (timer >= TIMER_LAST) begin
          state_n = S_IDLE;
          tmo_set = 1'b1;
        end
      end
      S_WAIT_FALL: begin
        if (busy_fall) begin
          state_n    = S_READ;
          rd_start_n = 1'b1;
        end else if (timer >= TIMER_LAST) begin
          state_n = S_IDLE;
          tmo_set = 1'b1;
        end
      end
      S_READ: begin
        // rd_done is ignored while the rd_start pulse itself is still high.
        if (rd_done && !rd_start) begin
          state_n = S_IDLE;
          valid_n = 1'b1;
          seq_n   = seq + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pulse_cnt    <= '0;
      timer        <= '0;
      conv         <= 1'b0;
      rd_start     <= 1'b0;
      sample_valid <= 1'b0;
      seq          <= '0;
      active       <= 1'b0;
    end else begin
      state        <= state_n;
      pulse_cnt    <= pulse_n;
      timer        <= timer_n;
      conv         <= (state_n == S_CONV);
      rd_start     <= rd_start_n;
      sample_valid <= valid_n;
      seq          <= seq_n;
      active       <= (state_n != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (tmo_set) begin
        timeout <= 1'b1;
      end else if (err_clr) begin
        timeout <= 1'b0;
      end
    end
  end

`ifdef AD7606_SCHED_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (ovr_set) begin
      if (overrun_cnt != '1) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
    end else if (err_clr) begin
      overrun_cnt <= '0;
    end
  end
`endif

endmodule
